// File: rtl/bht_controller.sv
// Branch history table controller.
// Owns a table of two-bit saturating taken/not-taken counters, sweeps it to a
// known value after reset or flush, and arbitrates one table access per cycle
// between the fetch-side lookup port and the execute-side update port.
module bht_controller #(
  parameter int         IDX_W      = 4,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  output logic             upd_ready,
  output logic             init_busy,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int DEPTH = 1 << IDX_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Starvation threshold: after this many consecutive update wins over a
  // waiting lookup, the lookup is forced through.
  localparam logic [1:0] STARVE_MAX = 2'd2;

  // Counter table. No reset: contents are only meaningful after the sweep.
  logic [1:0]       tbl_q [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic [1:0]       starve_q, starve_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic             in_run;
  logic             lk_wins;
  logic             lk_fire;
  logic             up_fire;
  logic [1:0]       upd_old;
  logic [1:0]       upd_new;
  logic             init_last;

  // Arbitration: updates win unless a lookup has waited long enough or no
  // update is requested. Exactly one port shows ready while running, so the
  // two readies can never be high together.
  always_comb begin
    in_run       = (state_q == ST_RUN);
    lk_wins      = lookup_valid && ((starve_q == STARVE_MAX) || !upd_valid);
    lookup_ready = in_run && lk_wins;
    upd_ready    = in_run && !lk_wins;
    // A flush in the same cycle voids whatever was granted.
    lk_fire      = lookup_valid && lookup_ready && !flush;
    up_fire      = upd_valid && upd_ready && !flush;
  end

  // Saturating read-modify-write value for the entry being updated.
  always_comb begin
    upd_old = tbl_q[upd_idx];
    upd_new = upd_old;
    if (upd_taken) begin
      if (upd_old != 2'b11) begin
        upd_new = upd_old + 2'b01;
      end
    end else begin
      if (upd_old != 2'b00) begin
        upd_new = upd_old - 2'b01;
      end
    end
  end

  // Next-state logic for FSM, sweep pointer, starvation guard and outputs.
  always_comb begin
    init_last    = &init_ptr_q;
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    starve_d     = starve_q;
    pred_valid_d = lk_fire;
    pred_taken_d = pred_taken_q;
    mcnt_d       = mcnt_q;

    if (flush) begin
      state_d    = ST_INIT;
      init_ptr_d = '0;
    end else if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_last) begin
        state_d = ST_RUN;
      end
    end

    // The guard only counts cycles in which a waiting lookup loses to an update.
    if (flush || !in_run || !lookup_valid || lookup_ready) begin
      starve_d = 2'd0;
    end else if (upd_valid) begin
      starve_d = starve_q + 2'd1;
    end

    if (lk_fire) begin
      pred_taken_d = tbl_q[lookup_idx][1];
    end

    if (up_fire && upd_mispredict && (mcnt_q != {CNT_W{1'b1}})) begin
      mcnt_d = mcnt_q + 1'b1;
    end
  end

  // Control and output registers; reset returns them immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      starve_q     <= 2'd0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      mcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      starve_q     <= starve_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      mcnt_q       <= mcnt_d;
    end
  end

  // Table writes: one sweep entry per cycle while initialising, otherwise
  // the granted update. Lookups and updates never share a cycle, so a read
  // always sees every write from earlier edges.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      tbl_q[init_ptr_q] <= INIT_STATE;
    end else if (up_fire) begin
      tbl_q[upd_idx] <= upd_new;
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign init_busy        = (state_q == ST_INIT);
  assign mispredict_count = mcnt_q;

endmodule

// File: tb/tb_bht_controller.sv
// Self-checking bench for bht_controller: a reference model drives a
// prediction scoreboard, plus a table of hand-derived vectors and short
// hand-written sequences for initialisation, flush, saturation and reset.
module tb_bht_controller;

  localparam int IDX_W = 4;
  localparam int CNT_W = 4;
  localparam int DEPTH = 1 << IDX_W;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_idx;
  logic             lookup_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_mispredict;
  logic             upd_ready;
  logic             init_busy;
  logic [CNT_W-1:0] mispredict_count;

  bht_controller #(
    .IDX_W     (IDX_W),
    .INIT_STATE(2'b01),
    .CNT_W     (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .lookup_valid    (lookup_valid),
    .lookup_idx      (lookup_idx),
    .lookup_ready    (lookup_ready),
    .pred_valid      (pred_valid),
    .pred_taken      (pred_taken),
    .upd_valid       (upd_valid),
    .upd_idx         (upd_idx),
    .upd_taken       (upd_taken),
    .upd_mispredict  (upd_mispredict),
    .upd_ready       (upd_ready),
    .init_busy       (init_busy),
    .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic       m_init;
  int         m_ptr;
  logic [1:0] m_tbl [DEPTH];
  int         m_starve;
  int         m_cnt;

  typedef struct {
    logic v;
    logic t;
  } sb_t;
  sb_t sb_q[$];

  // Readies sampled in the most recent step.
  logic s_lr, s_ur;

  typedef struct {
    logic             lv;
    logic [IDX_W-1:0] li;
    logic             uv;
    logic [IDX_W-1:0] ui;
    logic             ut;
    logic             um;
    logic             exp_lr;
    logic             exp_ur;
    logic             exp_taken;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_init   = 1'b1;
    m_ptr    = 0;
    m_starve = 0;
    m_cnt    = 0;
    sb_q.delete();
  endtask

  // One clock cycle: drive inputs, check readies mid-cycle, let the edge
  // happen, advance the model and check the registered outputs.
  task automatic step(input logic lv, input logic [IDX_W-1:0] li,
                      input logic uv, input logic [IDX_W-1:0] ui,
                      input logic ut, input logic um, input logic fl);
    logic m_lr, m_ur, lkw, g_lk, g_up;
    sb_t  e;
    sb_t  got;
    lookup_valid   = lv;
    lookup_idx     = li;
    upd_valid      = uv;
    upd_idx        = ui;
    upd_taken      = ut;
    upd_mispredict = um;
    flush          = fl;
    @(negedge clk);
    if (m_init) begin
      m_lr = 1'b0;
      m_ur = 1'b0;
    end else begin
      lkw  = lv && ((m_starve == 2) || !uv);
      m_lr = lkw;
      m_ur = !lkw;
    end
    s_lr = lookup_ready;
    s_ur = upd_ready;
    chk("lookup_ready", lookup_ready, m_lr);
    chk("upd_ready", upd_ready, m_ur);
    chk("ready_exclusive", lookup_ready & upd_ready, 0);
    g_lk = m_lr && lv && !fl;
    g_up = m_ur && uv && !fl;
    e.v = g_lk;
    e.t = g_lk ? m_tbl[li][1] : 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    // model advance
    if (fl || m_init || !lv || m_lr) m_starve = 0;
    else if (uv) m_starve = m_starve + 1;
    if (g_up) begin
      if (ut) m_tbl[ui] = (m_tbl[ui] == 2'b11) ? 2'b11 : m_tbl[ui] + 2'b01;
      else    m_tbl[ui] = (m_tbl[ui] == 2'b00) ? 2'b00 : m_tbl[ui] - 2'b01;
      if (um && m_cnt != (1 << CNT_W) - 1) m_cnt++;
    end
    if (fl) begin
      m_init = 1'b1;
      m_ptr  = 0;
    end else if (m_init) begin
      m_tbl[m_ptr] = 2'b01;
      if (m_ptr == DEPTH - 1) m_init = 1'b0;
      m_ptr = (m_ptr + 1) % DEPTH;
    end
    got = sb_q.pop_front();
    chk("pred_valid", pred_valid, got.v);
    if (got.v) chk("pred_taken", pred_taken, got.t);
    chk("init_busy", init_busy, m_init);
    chk("mispredict_count", mispredict_count, m_cnt);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Steps idle cycles until init_busy falls; returns the number of edges.
  task automatic count_init(input logic lv, output int n);
    n = 0;
    do begin
      step(lv, 4'd1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      n++;
    end while (init_busy && n < 40);
  endtask

  vec_t vecs [14];
  int   n;
  int   cnt_before;
  logic [2:0] pat;

  initial begin
    // saturation sequence on idx 3 (starting from 2'b01 after a fresh sweep)
    vecs[0]  = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // ->2
    vecs[1]  = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // ->3
    vecs[2]  = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // 3
    vecs[3]  = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // 3
    vecs[4]  = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // look
    vecs[5]  = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}; // ->2
    vecs[6]  = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // look
    vecs[7]  = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // ->1
    vecs[8]  = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // look
    vecs[9]  = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // ->0
    vecs[10] = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // 0
    vecs[11] = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // look
    vecs[12] = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // ->1
    vecs[13] = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // look

    reset = 1'b0;
    flush = 1'b0;
    lookup_valid = 1'b0;
    lookup_idx = '0;
    upd_valid = 1'b0;
    upd_idx = '0;
    upd_taken = 1'b0;
    upd_mispredict = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_init_busy", init_busy, 1);
    chk("rst_lookup_ready", lookup_ready, 0);
    chk("rst_upd_ready", upd_ready, 0);
    chk("rst_mispredict_count", mispredict_count, 0);

    // release between edges; the next edge writes entry 0
    reset = 1'b1;
    count_init(1'b0, n);
    chk("init_edges_after_reset", n, 16);

    step(1'b1, 4'd5, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("lookup5_valid", pred_valid, 1);
    chk("lookup5_taken", pred_taken, 0);

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].lv, vecs[i].li, vecs[i].uv, vecs[i].ui,
           vecs[i].ut, vecs[i].um, 1'b0);
      chk($sformatf("vec%0d_lookup_ready", i), s_lr, vecs[i].exp_lr);
      chk($sformatf("vec%0d_upd_ready", i), s_ur, vecs[i].exp_ur);
      if (vecs[i].lv) chk($sformatf("vec%0d_pred_taken", i), pred_taken, vecs[i].exp_taken);
    end
    chk("vec_mispredicts", mispredict_count, 2);

    // simultaneous requests: grant pattern upd, upd, lookup repeating
    idle();
    for (int i = 0; i < 9; i++) begin
      pat = 3'b100;
      step(1'b1, 4'(i), 1'b1, 4'd10, i[0], 1'b0, 1'b0);
      chk($sformatf("sim%0d_lookup_grant", i), s_lr, pat[i % 3]);
    end

    // flush mid-run after idx 7 reaches 3
    idle();
    repeat (3) step(1'b0, '0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'd7, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("idx7_before_flush", pred_taken, 1);
    cnt_before = int'(mispredict_count);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    count_init(1'b1, n);
    chk("init_edges_after_flush", n, 16);
    step(1'b1, 4'd7, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("idx7_after_flush", pred_taken, 0);
    chk("count_kept_by_flush", mispredict_count, cnt_before);

    // flush during the sweep restarts it from entry 0
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (5) idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    count_init(1'b0, n);
    chk("init_edges_after_reflush", n, 16);

    // lookup granted, then flush in the next cycle: prediction already out
    step(1'b1, 4'd4, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("pred_before_late_flush", pred_valid, 1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    count_init(1'b0, n);

    // mispredict statistic saturates at 15
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 4'd9, i[0], 1'b1, 1'b0);
    chk("mispredict_saturated", mispredict_count, 15);
    reset = 1'b0;
    #1;
    chk("mispredict_after_reset", mispredict_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    count_init(1'b0, n);
    chk("init_edges_after_reset2", n, 16);

    // asynchronous reset while a prediction is being presented
    step(1'b1, 4'd2, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("async_pre_pred_valid", pred_valid, 1);
    lookup_valid = 1'b1;
    upd_valid    = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("async_pred_valid", pred_valid, 0);
    chk("async_pred_taken", pred_taken, 0);
    chk("async_init_busy", init_busy, 1);
    chk("async_lookup_ready", lookup_ready, 0);
    chk("async_upd_ready", upd_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bht_controller.md
# bht_controller

Branch history table controller. It owns a table of 2^IDX_W two-bit saturating taken/not-taken counters. It sequences table initialisation after reset or flush, and arbitrates the single table access slot per cycle between the fetch-side lookup port and the execute-side update port. It sits between fetch (lookup/predict) and branch resolution (update), and supplies per-index predictions plus a mispredict statistic.

## Interface
- IDX_W, 4: table index width; table depth is 2^IDX_W entries.
- INIT_STATE, 2'b01: counter value written to every entry during initialisation (weakly not-taken).
- CNT_W, 16: width of the mispredict counter.

- clk  input  1  rising-edge clock; the block has one clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  one-cycle pulse; re-initialises the whole table.
- lookup_valid  input  1  lookup request.
- lookup_idx  input  IDX_W  table index to read.
- lookup_ready  output  1  lookup is granted this cycle.
- pred_valid  output  1  registered prediction is valid.
- pred_taken  output  1  prediction, equal to bit 1 of the counter.
- upd_valid  input  1  update request.
- upd_idx  input  IDX_W  table index to update.
- upd_taken  input  1  resolved branch outcome.
- upd_mispredict  input  1  the resolved branch was mispredicted.
- upd_ready  output  1  update is granted this cycle.
- init_busy  output  1  table initialisation is in progress.
- mispredict_count  output  CNT_W  saturating count of granted updates with upd_mispredict=1.

## Operation
- FSM states:
  - INIT: sweeps init_ptr from 0 to 2^IDX_W-1, writing INIT_STATE to one entry per cycle. init_busy=1; lookup_ready=0; upd_ready=0.
  - RUN: normal arbitration.
- Transitions:
  - Reset moves the FSM to INIT with init_ptr=0.
  - INIT moves to RUN on the edge that writes the last entry.
  - flush=1 in any state moves to INIT with init_ptr=0 on the next edge. A flush during INIT restarts the sweep at 0.
- RUN arbitration: at most one table access per cycle.
  - Updates have fixed priority over lookups, subject to the starvation guard.
  - Starvation guard: starve_cnt (2 bits) increments each cycle that lookup_valid=1 and an update is granted instead. When starve_cnt==2, the lookup is granted and upd_ready=0 for that cycle. starve_cnt clears on every lookup grant and whenever lookup_valid=0.
  - lookup_ready and upd_ready are combinational from the valids, the FSM state and starve_cnt. They are never both 1.
  - With no request pending, ready is still driven for the port that would win. A valid=0 grant has no effect.
- Update on a granted cycle (upd_valid and upd_ready both 1):
  - upd_taken=1: counter = min(counter+1, 3).
  - upd_taken=0: counter = max(counter-1, 0).
  - The table is written at the grant edge.
  - If upd_mispredict=1, mispredict_count increments, saturating at 2^CNT_W-1.
- Lookup on a granted cycle: the table entry at lookup_idx is read. The read value includes all updates written on earlier edges.
- flush does not clear mispredict_count; only reset clears it. flush has priority over any grant issued in the same cycle: that grant's write or read does not occur.

## Timing
- Reset values:
  - FSM=INIT, init_ptr=0.
  - lookup_ready=0, upd_ready=0.
  - pred_valid=0, pred_taken=0.
  - init_busy=1.
  - mispredict_count=0.
  - Table contents are undefined until INIT completes.
- Initialisation sequence:
  - The first rising edge with reset high writes entry 0.
  - Edge k writes entry k-1.
  - Edge 2^IDX_W writes the last entry and enters RUN.
  - init_busy falls after that edge; grants are possible in the same cycle.
- Lookup latency is 1 cycle:
  - A grant at edge t gives pred_valid=1 and pred_taken=counter[lookup_idx][1] after edge t.
  - Both outputs hold until the next edge.
  - pred_valid=0 on any edge without a lookup grant.
- An update granted at edge t is visible to a lookup granted at edge t+1 or later.
- A flush asserted in the cycle after a lookup grant does not cancel the pending pred_valid.
- Reset asserted mid-operation returns all outputs to their reset values immediately (asynchronously).

## Test plan
- Reset release, IDX_W=4, no requests:
  - init_busy=1 for exactly 16 edges, then 0.
  - A lookup of idx 5 then returns pred_valid=1, pred_taken=0 one cycle later.
- Saturation on idx 3:
  - Updates taken=1 ×4 from 2'b01: counter reaches 3 and stays 3; lookup gives pred_taken=1.
  - Then taken=0 ×4: counter goes 2, 1, 0, 0; lookup gives pred_taken=0.
- Simultaneous requests:
  - upd_valid=1 and lookup_valid=1 held every cycle.
  - Grant pattern is upd, upd, lookup, repeating.
  - lookup_ready and upd_ready are never both 1.
- Flush mid-run after idx 7 reaches 3:
  - One-cycle flush gives init_busy=1 for 16 edges.
  - A lookup of idx 7 then gives pred_taken=0.
  - mispredict_count is unchanged.
- Mispredict statistic, CNT_W=4:
  - 20 granted updates with upd_mispredict=1: mispredict_count saturates at 15.
  - Reset returns it to 0.
- Asynchronous reset mid-run:
  - reset low between clock edges while pred_valid=1 forces pred_valid=0, init_busy=1, and lookup_ready=0 and upd_ready=0 before the next edge.
